// File: rtl/spi_ram_pkg.sv
// Shared command codes, read-FSM states and sizing helper for the SPI RAM controller.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic {
    NO_RADDR = 1'b0,
    RADDR_OK = 1'b1
  } rd_state_t;

  // Index width needed for a memory of the given depth (at least one bit).
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Synchronous single-port MEM_DEPTH x 8 array; read data is registered and
// only updates on a read enable, so it holds between reads. No reset.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic                            re,
  input  logic [addr_bits(MEM_DEPTH)-1:0] addr,
  input  logic [7:0]                      wdata,
  output logic [7:0]                      rdata
);

  logic [7:0] mem [MEM_DEPTH];

  // Write port and registered read port sharing one address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder for the SPI slave: edge-detects rx_valid, maintains write and
// read address registers, range-checks them on use and returns read data with
// one-cycle tx_valid / err strobes.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);

  localparam int                   AW        = addr_bits(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0]   DEPTH_W   = (ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  logic                 rx_valid_q;
  logic                 accept;
  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] payload;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  rd_state_t            state;
  logic                 rd_hit;
  logic                 wr_oor;
  logic                 rd_oor;
  logic                 mem_we;
  logic                 mem_re;
  logic [AW-1:0]        mem_addr;
  logic [7:0]           mem_rdata;

  // Decode, range checks, memory strobes and output data select.
  // dout is zero after reset and after an out-of-range read (rd_hit clear);
  // otherwise it is the memory's held read register, which only moves on a good read.
  always_comb begin
    accept   = rx_valid & ~rx_valid_q;
    cmd      = din[9:8];
    payload  = din[ADDR_SIZE-1:0];
    wr_oor   = {1'b0, wr_addr} >= DEPTH_W;
    rd_oor   = {1'b0, rd_addr} >= DEPTH_W;
    mem_we   = accept && (cmd == CMD_WR_DATA) && !wr_oor;
    mem_re   = accept && (cmd == CMD_RD_DATA) && (state == RADDR_OK) && !rd_oor;
    mem_addr = (cmd == CMD_WR_DATA) ? wr_addr[AW-1:0] : rd_addr[AW-1:0];
    dout     = rd_hit ? mem_rdata : '0;
  end

  // Edge detect, address registers, read FSM and single-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      state      <= NO_RADDR;
      rd_hit     <= 1'b0;
      tx_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      tx_valid   <= 1'b0;
      err        <= 1'b0;
      if (accept) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr <= payload;
          CMD_WR_DATA: begin
            // A dropped out-of-range write leaves wr_addr where it was.
            if (wr_oor) begin
              err <= 1'b1;
            end else if (AUTO_INC != 0) begin
              wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
            end
          end
          CMD_RD_ADDR: begin
            rd_addr <= payload;
            state   <= RADDR_OK;
          end
          default: begin
            if (state == RADDR_OK) begin
              tx_valid <= 1'b1;
              state    <= NO_RADDR;
              if (rd_oor) begin
                err    <= 1'b1;
                rd_hit <= 1'b0;
              end else begin
                rd_hit <= 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  spi_ram_mem #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(din[7:0]),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: instance a uses default sizing (256 words,
// no auto-increment), instance b uses 16 words with auto-increment.
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  typedef struct {
    bit         sel;       // 0 = dut_a, 1 = dut_b
    logic [1:0] cmd;
    logic [7:0] pl;
    int         hold;      // cycles rx_valid stays high
    logic       exp_tx;
    logic       exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] din_a, din_b;
  logic       rx_a, rx_b;
  logic [7:0] dout_a, dout_b;
  logic       tx_a, tx_b, err_a, err_b;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  spi_ram_ctrl dut_a (
    .clk(clk), .rst(rst), .din(din_a), .rx_valid(rx_a),
    .dout(dout_a), .tx_valid(tx_a), .err(err_a)
  );

  spi_ram_ctrl #(
    .MEM_DEPTH(16), .ADDR_SIZE(8), .AUTO_INC(1)
  ) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .rx_valid(rx_b),
    .dout(dout_b), .tx_valid(tx_b), .err(err_b)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [9:0] w, input logic r);
    if (sel) begin
      din_b = w;
      rx_b  = r;
    end else begin
      din_a = w;
      rx_a  = r;
    end
  endtask

  task automatic sample(input bit sel, output logic tx, output logic er, output logic [7:0] d);
    tx = sel ? tx_b : tx_a;
    er = sel ? err_b : err_a;
    d  = sel ? dout_b : dout_a;
  endtask

  function automatic vec_t mk(input bit sel, input logic [1:0] cmd, input logic [7:0] pl,
                              input int hold, input logic tx, input logic er, input logic [7:0] d);
    vec_t v;
    v.sel = sel; v.cmd = cmd; v.pl = pl; v.hold = hold;
    v.exp_tx = tx; v.exp_err = er; v.exp_dout = d;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    logic       tx, er;
    logic [7:0] d;
    @(negedge clk);
    drive(v.sel, {v.cmd, v.pl}, 1'b1);
    @(negedge clk);
    sample(v.sel, tx, er, d);
    chk({tag, "_tx"},   {7'b0, tx}, {7'b0, v.exp_tx});
    chk({tag, "_err"},  {7'b0, er}, {7'b0, v.exp_err});
    chk({tag, "_dout"}, d, v.exp_dout);
    for (int k = 1; k < v.hold; k++) begin
      @(negedge clk);
      sample(v.sel, tx, er, d);
      chk({tag, "_hold_tx"},   {7'b0, tx}, 8'h00);
      chk({tag, "_hold_err"},  {7'b0, er}, 8'h00);
      chk({tag, "_hold_dout"}, d, v.exp_dout);
    end
    drive(v.sel, {v.cmd, v.pl}, 1'b0);
    @(negedge clk);
    sample(v.sel, tx, er, d);
    chk({tag, "_end_tx"},  {7'b0, tx}, 8'h00);
    chk({tag, "_end_err"}, {7'b0, er}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // dut_a: 256 words, no auto-increment
    tbl.push_back(mk(0, CMD_WR_ADDR, 8'h12, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, CMD_WR_DATA, 8'hA5, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, CMD_RD_ADDR, 8'h12, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'hA5));
    tbl.push_back(mk(0, CMD_WR_ADDR, 8'h05, 1, 0, 0, 8'hA5));
    tbl.push_back(mk(0, CMD_WR_DATA, 8'h5A, 1, 0, 0, 8'hA5));
    tbl.push_back(mk(0, CMD_WR_DATA, 8'h5B, 1, 0, 0, 8'hA5));
    tbl.push_back(mk(0, CMD_RD_ADDR, 8'h05, 1, 0, 0, 8'hA5));
    tbl.push_back(mk(0, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'h5B));
    tbl.push_back(mk(0, CMD_RD_DATA, 8'h00, 1, 0, 1, 8'h5B));
    tbl.push_back(mk(0, CMD_RD_ADDR, 8'h40, 1, 0, 0, 8'h5B));
    tbl.push_back(mk(0, CMD_RD_ADDR, 8'h12, 1, 0, 0, 8'h5B));
    tbl.push_back(mk(0, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'hA5));
    tbl.push_back(mk(0, CMD_WR_ADDR, 8'hFF, 1, 0, 0, 8'hA5));
    tbl.push_back(mk(0, CMD_WR_DATA, 8'h77, 1, 0, 0, 8'hA5));
    tbl.push_back(mk(0, CMD_RD_ADDR, 8'hFF, 1, 0, 0, 8'hA5));
    tbl.push_back(mk(0, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'h77));
    tbl.push_back(mk(0, CMD_WR_ADDR, 8'h12, 1, 0, 0, 8'h77));
    tbl.push_back(mk(0, CMD_WR_DATA, 8'hC3, 1, 0, 0, 8'h77));
    tbl.push_back(mk(0, CMD_RD_ADDR, 8'h12, 1, 0, 0, 8'h77));
    tbl.push_back(mk(0, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'hC3));
    // dut_b: 16 words, auto-increment
    tbl.push_back(mk(1, CMD_WR_ADDR, 8'h0F, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, CMD_WR_DATA, 8'h11, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, CMD_WR_DATA, 8'h22, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, CMD_RD_ADDR, 8'h0F, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'h11));
    tbl.push_back(mk(1, CMD_RD_ADDR, 8'h00, 1, 0, 0, 8'h11));
    tbl.push_back(mk(1, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'h22));
    tbl.push_back(mk(1, CMD_WR_ADDR, 8'h20, 1, 0, 0, 8'h22));
    tbl.push_back(mk(1, CMD_WR_DATA, 8'h55, 1, 0, 1, 8'h22));
    tbl.push_back(mk(1, CMD_RD_ADDR, 8'h20, 1, 0, 0, 8'h22));
    tbl.push_back(mk(1, CMD_RD_DATA, 8'h00, 1, 1, 1, 8'h00));
    tbl.push_back(mk(1, CMD_RD_ADDR, 8'h00, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'h22));
    tbl.push_back(mk(1, CMD_WR_ADDR, 8'h10, 1, 0, 0, 8'h22));
    tbl.push_back(mk(1, CMD_WR_DATA, 8'h66, 1, 0, 1, 8'h22));
    tbl.push_back(mk(1, CMD_RD_ADDR, 8'h10, 1, 0, 0, 8'h22));
    tbl.push_back(mk(1, CMD_RD_DATA, 8'h00, 1, 1, 1, 8'h00));
    tbl.push_back(mk(1, CMD_WR_ADDR, 8'h01, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, CMD_WR_DATA, 8'h99, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, CMD_WR_ADDR, 8'h00, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, CMD_WR_DATA, 8'h3C, 5, 0, 0, 8'h00));
    tbl.push_back(mk(1, CMD_RD_ADDR, 8'h01, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'h99));
    tbl.push_back(mk(1, CMD_RD_ADDR, 8'h00, 1, 0, 0, 8'h99));
    tbl.push_back(mk(1, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'h3C));
    tbl.push_back(mk(1, CMD_WR_DATA, 8'h44, 1, 0, 0, 8'h3C));
    tbl.push_back(mk(1, CMD_RD_ADDR, 8'h01, 1, 0, 0, 8'h3C));
    tbl.push_back(mk(1, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'h44));
    tbl.push_back(mk(1, CMD_RD_DATA, 8'h00, 1, 0, 1, 8'h44));

    din_a = '0; din_b = '0; rx_a = 1'b0; rx_b = 1'b0; rst = 1'b0;

    // Reset with rx_valid already high and an RD_DATA word on din
    #2;
    rst = 1'b1;
    din_a = 10'h3FF; din_b = 10'h3FF; rx_a = 1'b1; rx_b = 1'b1;
    #1;
    chk("rst_async_dout_a", dout_a, 8'h00);
    chk("rst_async_tx_a",   {7'b0, tx_a}, 8'h00);
    chk("rst_async_err_a",  {7'b0, err_a}, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_hold_dout_b", dout_b, 8'h00);
    chk("rst_hold_tx_b",   {7'b0, tx_b}, 8'h00);
    chk("rst_hold_err_b",  {7'b0, err_b}, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_err_a",  {7'b0, err_a}, 8'h01);
    chk("rel_tx_a",   {7'b0, tx_a}, 8'h00);
    chk("rel_dout_a", dout_a, 8'h00);
    chk("rel_err_b",  {7'b0, err_b}, 8'h01);
    chk("rel_tx_b",   {7'b0, tx_b}, 8'h00);
    rx_a = 1'b0; rx_b = 1'b0;
    @(negedge clk);
    chk("rel_end_err_a", {7'b0, err_a}, 8'h00);
    chk("rel_end_err_b", {7'b0, err_b}, 8'h00);

    foreach (tbl[i]) begin
      apply(tbl[i], $sformatf("v%0d_%s", i, tbl[i].sel ? "b" : "a"));
    end

    // Reset while a read response is on the outputs
    apply(mk(0, CMD_RD_ADDR, 8'h12, 1, 0, 0, 8'hC3), "mid_rdaddr_a");
    @(negedge clk);
    drive(0, {CMD_RD_DATA, 8'h00}, 1'b1);
    @(posedge clk);
    #1;
    chk("mid_tx_before_rst",   {7'b0, tx_a}, 8'h01);
    chk("mid_dout_before_rst", dout_a, 8'hC3);
    rst = 1'b1;
    #1;
    chk("mid_tx_cancel",  {7'b0, tx_a}, 8'h00);
    chk("mid_dout_clear", dout_a, 8'h00);
    chk("mid_err_clear",  {7'b0, err_a}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_err", {7'b0, err_a}, 8'h01);
    chk("mid_rel_tx",  {7'b0, tx_a}, 8'h00);
    drive(0, {CMD_RD_DATA, 8'h00}, 1'b0);
    @(negedge clk);
    chk("mid_rel_end_err", {7'b0, err_a}, 8'h00);

    // Memory contents survive reset
    apply(mk(0, CMD_RD_ADDR, 8'h12, 1, 0, 0, 8'h00), "keep_rdaddr_a");
    apply(mk(0, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'hC3), "keep_rddata_a");
    apply(mk(1, CMD_RD_ADDR, 8'h01, 1, 0, 0, 8'h00), "keep_rdaddr_b");
    apply(mk(1, CMD_RD_DATA, 8'h00, 1, 1, 0, 8'h44), "keep_rddata_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
